// File: rtl/load_store_unit.sv
// Load/store unit: latches one execute-stage request, issues a single memory access
// with byte lanes and replicated store data, and returns the extended load result.
module load_store_unit #(
   parameter int ADDR_W  = 12,
   parameter int TIMEOUT = 15
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              is_store,
   input  logic [2:0]        funct3,
   input  logic [31:0]       addr,
   input  logic [31:0]       wdata,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [3:0]        mem_be,
   output logic [31:0]       mem_wdata,
   input  logic [31:0]       mem_rdata,
   input  logic              mem_ack,
   output logic              done,
   output logic [31:0]       rdata,
   output logic              err,
   output logic [1:0]        err_code
);

   typedef enum logic [1:0] {IDLE, ISSUE, DONE} state_t;

   state_t      state, state_nxt;
   logic [3:0]  wait_cnt;
   logic        st_p0;
   logic [2:0]  f3_p0;
   logic [31:0] addr_p0;
   logic [31:0] wdata_p0;
   logic [31:0] rdata_q;
   logic        err_q;
   logic [1:0]  err_code_q;
   logic        illegal, misal, timed_out;
   logic        unused_addr_hi;

   function automatic logic [3:0] store_be(input logic [2:0] f3, input logic [1:0] a);
      case (f3[1:0])
         2'b00:   return 4'b0001 << a;
         2'b01:   return a[1] ? 4'b1100 : 4'b0011;
         default: return 4'b1111;
      endcase
   endfunction

   function automatic logic [31:0] store_data(input logic [2:0] f3, input logic [31:0] d);
      case (f3[1:0])
         2'b00:   return {4{d[7:0]}};
         2'b01:   return {2{d[15:0]}};
         default: return d;
      endcase
   endfunction

   function automatic logic [31:0] load_extend(input logic [2:0] f3, input logic [1:0] a,
                                               input logic [31:0] d);
      logic signed [7:0]  b;
      logic signed [15:0] h;
      b = d[{a, 3'b000} +: 8];
      h = a[1] ? d[31:16] : d[15:0];
      case (f3)
         3'b000:  return 32'(b);
         3'b001:  return 32'(h);
         3'b100:  return {24'd0, b};
         3'b101:  return {16'd0, h};
         default: return d;
      endcase
   endfunction

   assign illegal   = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
   assign misal     = ((funct3[1:0] == 2'b01) && addr[0]) ||
                      ((funct3 == 3'b010) && (addr[1:0] != 2'b00));
   assign timed_out = (wait_cnt == 4'(TIMEOUT - 1));
   assign unused_addr_hi = ^addr_p0[31:ADDR_W+2];

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state    <= IDLE;
         wait_cnt <= '0;
      end else begin
         state    <= state_nxt;
         wait_cnt <= (state == ISSUE) ? wait_cnt + 4'd1 : 4'd0;
      end
   end

   always_comb begin
      state_nxt = state;
      req_ready = 1'b0;
      mem_req   = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_be    = 4'b0000;
      mem_wdata = '0;
      done      = 1'b0;
      case (state)
         IDLE: begin
            req_ready = 1'b1;
            if (req_valid) state_nxt = (illegal || misal) ? DONE : ISSUE;
         end
         ISSUE: begin
            mem_req   = 1'b1;
            mem_we    = st_p0;
            mem_addr  = addr_p0[ADDR_W+1:2];
            mem_be    = st_p0 ? store_be(f3_p0, addr_p0[1:0]) : 4'b1111;
            mem_wdata = st_p0 ? store_data(f3_p0, wdata_p0) : 32'd0;
            if (mem_ack || timed_out) state_nxt = DONE;
         end
         DONE: begin
            done      = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // request latch and completion status
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         st_p0      <= 1'b0;
         f3_p0      <= 3'b000;
         addr_p0    <= '0;
         wdata_p0   <= '0;
         rdata_q    <= '0;
         err_q      <= 1'b0;
         err_code_q <= 2'b00;
      end else begin
         if (state == IDLE && req_valid) begin
            st_p0      <= is_store;
            f3_p0      <= funct3;
            addr_p0    <= addr;
            wdata_p0   <= wdata;
            err_q      <= illegal || misal;
            err_code_q <= illegal ? 2'b11 : (misal ? 2'b01 : 2'b00);
         end
         if (state == ISSUE) begin
            if (mem_ack) begin
               if (!st_p0) rdata_q <= load_extend(f3_p0, addr_p0[1:0], mem_rdata);
            end else if (timed_out) begin
               err_q      <= 1'b1;
               err_code_q <= 2'b10;
            end
         end
      end
   end

   assign rdata    = rdata_q;
   assign err      = err_q;
   assign err_code = err_code_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed cases plus random requests against an arithmetic model.
module tb_load_store_unit;

   localparam int AW = 12;
   localparam int TO = 15;

   logic          CLK = 1'b0;
   logic          RST;
   logic          req_valid, req_ready, is_store;
   logic [2:0]    funct3;
   logic [31:0]   addr, wdata;
   logic          mem_req, mem_we;
   logic [AW-1:0] mem_addr;
   logic [3:0]    mem_be;
   logic [31:0]   mem_wdata, mem_rdata;
   logic          mem_ack, done, err;
   logic [31:0]   rdata;
   logic [1:0]    err_code;

   int checks = 0;
   int errors = 0;
   logic [31:0] exp_rdata = 32'd0;

   load_store_unit #(.ADDR_W(AW), .TIMEOUT(TO)) dut (
      .CLK(CLK), .RST(RST), .req_valid(req_valid), .req_ready(req_ready),
      .is_store(is_store), .funct3(funct3), .addr(addr), .wdata(wdata),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
      .done(done), .rdata(rdata), .err(err), .err_code(err_code)
   );

   always #5 CLK = ~CLK;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] m_load(input int f3, input logic [31:0] a, input logic [31:0] d);
      logic [31:0] v;
      case (f3)
         0, 4: begin
            v = (d >> (8 * (a % 4))) & 32'd255;
            if (f3 == 0 && v >= 32'd128) v = v + 32'hFFFFFF00;
         end
         1, 5: begin
            v = (d >> (16 * ((a % 4) / 2))) & 32'd65535;
            if (f3 == 1 && v >= 32'd32768) v = v + 32'hFFFF0000;
         end
         default: v = d;
      endcase
      return v;
   endfunction

   function automatic logic [31:0] m_be(input bit st, input int f3, input logic [31:0] a);
      if (!st || f3 == 2) return 32'd15;
      if (f3 == 0) return 32'd1 << (a % 4);
      return ((a % 4) >= 2) ? 32'd12 : 32'd3;
   endfunction

   function automatic logic [31:0] m_wd(input int f3, input logic [31:0] w);
      if (f3 == 0) return (w & 32'd255) * 32'h01010101;
      if (f3 == 1) return (w & 32'd65535) * 32'h00010001;
      return w;
   endfunction

   function automatic int m_code(input int f3, input logic [31:0] a);
      if (f3 == 3 || f3 == 6 || f3 == 7) return 3;
      if ((f3 == 1 || f3 == 5) && (a % 2) != 0) return 1;
      if (f3 == 2 && (a % 4) != 0) return 1;
      return 0;
   endfunction

   // ack_at: ISSUE cycle index (0-based) carrying mem_ack; >= TO means never acked
   task automatic txn(input bit st, input int f3, input logic [31:0] a, input logic [31:0] wd,
                      input int ack_at, input logic [31:0] rd);
      int  code, reqcnt;
      bit  fin;
      code = m_code(f3, a);
      @(negedge CLK);
      check("ready_idle", req_ready, 1);
      check("done_idle", done, 0);
      req_valid = 1'b1; is_store = st; funct3 = 3'(f3); addr = a; wdata = wd;
      mem_ack = 1'($urandom_range(0, 1)); mem_rdata = $urandom;
      @(negedge CLK);
      req_valid = 1'b0; mem_ack = 1'b0; addr = $urandom; wdata = $urandom;
      if (code != 0) begin
         check("err_done", done, 1);
         check("err_memreq", mem_req, 0);
         check("err_flag", err, 1);
         check("err_code", err_code, code);
         check("err_rdata", rdata, exp_rdata);
         return;
      end
      reqcnt = 0;
      fin = 1'b0;
      for (int k = 0; k < TO + 4 && !fin; k++) begin
         check("issue_req", mem_req, 1);
         check("issue_done", done, 0);
         if (k == 0) begin
            check("mem_we", mem_we, st);
            check("mem_addr", mem_addr, (a >> 2) & ((32'd1 << AW) - 1));
            check("mem_be", mem_be, m_be(st, f3, a));
            if (st) check("mem_wdata", mem_wdata, m_wd(f3, wd));
         end
         mem_ack = (k == ack_at);
         mem_rdata = (k == ack_at) ? rd : $urandom;
         reqcnt++;
         @(negedge CLK);
         mem_ack = 1'b0;
         if (k == ack_at || k == TO - 1) fin = 1'b1;
      end
      check("req_cycles", reqcnt, (ack_at < TO) ? ack_at + 1 : TO);
      check("done_pulse", done, 1);
      check("done_memreq", mem_req, 0);
      if (ack_at < TO) begin
         if (!st) exp_rdata = m_load(f3, a, rd);
         check("ok_err", err, 0);
         check("ok_code", err_code, 0);
      end else begin
         check("to_err", err, 1);
         check("to_code", err_code, 2);
      end
      check("rdata", rdata, exp_rdata);
   endtask

   initial begin
      RST = 1'b1; req_valid = 1'b0; is_store = 1'b0; funct3 = 3'b000;
      addr = 32'd0; wdata = 32'd0; mem_rdata = 32'd0; mem_ack = 1'b0;
      repeat (2) @(posedge CLK);
      @(negedge CLK);
      check("rst_ready", req_ready, 1);
      check("rst_memreq", mem_req, 0);
      check("rst_we", mem_we, 0);
      check("rst_be", mem_be, 0);
      check("rst_addr", mem_addr, 0);
      check("rst_wdata", mem_wdata, 0);
      check("rst_done", done, 0);
      check("rst_err", {err, err_code}, 0);
      check("rst_rdata", rdata, 0);
      RST = 1'b0;

      txn(0, 2, 32'h10, 32'h0, 0, 32'h12345678);
      txn(0, 0, 32'h3, 32'h0, 0, 32'h80AABBCC);
      check("lb_value", rdata, 32'hFFFFFF80);
      txn(0, 4, 32'h3, 32'h0, 0, 32'h80AABBCC);
      check("lbu_value", rdata, 32'h00000080);
      txn(1, 1, 32'h6, 32'h0000BEEF, 0, 32'h0);
      txn(0, 2, 32'h1, 32'h0, 0, 32'h0);
      txn(0, 3, 32'h1, 32'h0, 0, 32'h0);
      txn(0, 2, 32'h20, 32'h0, TO + 5, 32'h0);
      txn(0, 2, 32'h24, 32'h0, TO - 1, 32'hCAFEF00D);

      // reset while in ISSUE drops the request
      @(negedge CLK);
      req_valid = 1'b1; is_store = 1'b0; funct3 = 3'b010; addr = 32'h40;
      @(negedge CLK);
      req_valid = 1'b0;
      check("pre_rst_req", mem_req, 1);
      RST = 1'b1;
      #1;
      exp_rdata = 32'd0;
      check("mid_rst_req", mem_req, 0);
      check("mid_rst_done", done, 0);
      check("mid_rst_ready", req_ready, 1);
      check("mid_rst_rdata", rdata, 0);
      @(negedge CLK);
      RST = 1'b0;
      mem_ack = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge CLK);
         check("post_rst_done", done, 0);
         check("post_rst_req", mem_req, 0);
      end
      mem_ack = 1'b0;
      txn(0, 5, 32'h42, 32'h0, 1, 32'h9ABC1234);

      for (int n = 0; n < 60; n++) begin
         bit st;
         int f3, sel, ack;
         st  = 1'($urandom_range(0, 1));
         sel = $urandom_range(0, 9);
         if (st) f3 = (sel < 8) ? sel % 3 : 3 + 3 * (sel % 2);
         else    f3 = (sel < 5) ? sel : 3 + 3 * (sel % 2) + (sel % 3 == 0 ? 1 : 0);
         if (f3 > 7) f3 = 7;
         ack = ($urandom_range(0, 9) == 0) ? TO + $urandom_range(0, 2) : $urandom_range(0, 3);
         txn(st, f3, $urandom, $urandom, ack, $urandom);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
